mcp_control_unit: RTL and testbench

MCP_CONTROL_UNIT -- requirements
Module: mcp_control_unit

---
 rtl/mcp_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mcp_control_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mcp_control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM driving datapath controls,
// ALU control decode, PC enable and a retired-instruction counter.
module mcp_control_unit #(
    parameter int unsigned OPW = 6,
    parameter int unsigned CW  = 32
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [OPW-1:0] Opcode,
    input  logic [OPW-1:0] Funct,
    input  logic           Zero,
    output logic           IorD,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           RFWE,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [2:0]     ALUControl,
    output logic [1:0]     PCSrc,
    output logic           PCEn,
    output logic           BadOp,
    output logic [CW-1:0]  InstrCnt
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    localparam logic [OPW-1:0] FN_ADD   = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_SUB   = OPW'(6'b100010);
    localparam logic [OPW-1:0] FN_AND   = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_OR    = OPW'(6'b100101);
    localparam logic [OPW-1:0] FN_SLT   = OPW'(6'b101010);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
    } state_t;

    // NONE leaves ALUControl at 0 in states that do not use the ALU
    typedef enum logic [1:0] {
        ALUOP_NONE, ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
    } aluop_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   instr_cnt_q, instr_cnt_d;
    state_t          dec_state;
    logic            dec_bad;
    logic            retire;

    logic            iord, mem_write, ir_write, reg_dst, mem_to_reg, rf_we;
    logic            alu_src_a, pc_write, branch, bad_op;
    logic [1:0]      alu_src_b, pc_src;
    logic [2:0]      alu_ctl;
    aluop_t          alu_op;

    // State and counter registers; reset aborts any instruction in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Opcode decode used for the DECODE-state branch and the BadOp flag
    always_comb begin
        dec_state = S_FETCH;
        dec_bad   = 1'b0;
        case (Opcode)
            OP_LW, OP_SW: dec_state = S_MEMADR;
            OP_RTYPE:     dec_state = S_EXEC;
            OP_BEQ:       dec_state = S_BRANCH;
            OP_ADDI:      dec_state = S_ADDIEXEC;
            OP_J:         dec_state = S_JUMP;
            default:      dec_bad   = 1'b1;
        endcase
    end

    // Next-state logic; retire marks the completion of a valid instruction
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = dec_state;
            S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXEC:     state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        instr_cnt_d = retire ? instr_cnt_q + CW'(1) : instr_cnt_q;
    end

    // Moore output decode per state
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        rf_we      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        bad_op     = 1'b0;
        alu_op     = ALUOP_NONE;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_op    = ALUOP_ADD;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
                bad_op    = dec_bad;
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                rf_we      = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst = 1'b1;
                rf_we   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIWB: rf_we = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control decode; unknown funct codes fall back to add
    always_comb begin
        alu_ctl = 3'b000;
        case (alu_op)
            ALUOP_ADD: alu_ctl = 3'b010;
            ALUOP_SUB: alu_ctl = 3'b110;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  alu_ctl = 3'b010;
                    FN_SUB:  alu_ctl = 3'b110;
                    FN_AND:  alu_ctl = 3'b000;
                    FN_OR:   alu_ctl = 3'b001;
                    FN_SLT:  alu_ctl = 3'b111;
                    default: alu_ctl = 3'b010;
                endcase
            end
            default:   alu_ctl = 3'b000;
        endcase
    end

    // Reset forces every control low without waiting for a clock edge
    assign IorD       = RST_N & iord;
    assign MemWrite   = RST_N & mem_write;
    assign IRWrite    = RST_N & ir_write;
    assign RegDst     = RST_N & reg_dst;
    assign MemtoReg   = RST_N & mem_to_reg;
    assign RFWE       = RST_N & rf_we;
    assign ALUSrcA    = RST_N & alu_src_a;
    assign ALUSrcB    = RST_N ? alu_src_b : 2'b00;
    assign ALUControl = RST_N ? alu_ctl : 3'b000;
    assign PCSrc      = RST_N ? pc_src : 2'b00;
    assign PCEn       = RST_N & (pc_write | (branch & Zero));
    assign BadOp      = RST_N & bad_op;
    assign InstrCnt   = instr_cnt_q;

endmodule

// File: tb/tb_mcp_control_unit.sv
// Self-checking bench for mcp_control_unit: per-cycle vector table plus
// directed reset-abort and counter-wrap sequences.
module tb_mcp_control_unit;

    logic        CLK, RST_N, Zero;
    logic [5:0]  Opcode, Funct;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RFWE, ALUSrcA, PCEn, BadOp;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic [31:0] InstrCnt;
    logic [15:0] outs;

    mcp_control_unit #(.OPW(6), .CW(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RFWE(RFWE), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .BadOp(BadOp),
        .InstrCnt(InstrCnt)
    );

    assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RFWE, ALUSrcA,
                   ALUSrcB, ALUControl, PCSrc, PCEn, BadOp};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] mk(input logic iord, mw, irw, rd, m2r, we, sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic pcen, bad);
        return {iord, mw, irw, rd, m2r, we, sa, sb, ac, ps, pcen, bad};
    endfunction

    localparam logic [15:0] E_F    = mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
    localparam logic [15:0] E_D    = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
    localparam logic [15:0] E_DBAD = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
    localparam logic [15:0] E_MA   = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
    localparam logic [15:0] E_MR   = mk(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
    localparam logic [15:0] E_MWB  = mk(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0);
    localparam logic [15:0] E_MW   = mk(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
    localparam logic [15:0] E_AWB  = mk(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0);
    localparam logic [15:0] E_BR1  = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
    localparam logic [15:0] E_BR0  = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
    localparam logic [15:0] E_IWB  = mk(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0);
    localparam logic [15:0] E_J    = mk(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);
    localparam logic [15:0] M_ALL  = 16'hFFFF;
    localparam logic [15:0] M_NOAC = 16'hFF8F;   // ALUControl not defined in this state

    localparam logic [5:0] J_OP = 6'b000100;     // junk driven where opcode is not sampled
    localparam logic [5:0] J_FN = 6'b100010;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [15:0] exp;
        logic [15:0] mask;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic [5:0] op, fn, input logic z,
                       input logic [15:0] exp, mask, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.exp = exp; v.mask = mask; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic add_rtype(input logic [5:0] fn, input logic [2:0] ac, input logic [31:0] c);
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, c);
        add(6'b000000, J_FN, 1'b0, E_D, M_ALL, c);
        add(6'b000000, fn, 1'b1, mk(0,0,0,0,0,0,1,2'b00,ac,2'b00,0,0), M_ALL, c);
        add(J_OP, J_FN, 1'b1, E_AWB, M_NOAC, c);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, fn, input logic z);
        @(negedge CLK);
        Opcode = op; Funct = fn; Zero = z;
        #1;
    endtask

    initial begin
        RST_N = 1'b0; Opcode = J_OP; Funct = J_FN; Zero = 1'b1;

        // lw, 5 cycles
        add(J_OP, J_FN, 1'b1, E_F, M_ALL, 0);
        add(6'b100011, J_FN, 1'b1, E_D, M_ALL, 0);
        add(6'b100011, J_FN, 1'b1, E_MA, M_ALL, 0);
        add(J_OP, J_FN, 1'b1, E_MR, M_NOAC, 0);
        add(J_OP, J_FN, 1'b1, E_MWB, M_NOAC, 0);
        // sw, 4 cycles
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 1);
        add(6'b101011, J_FN, 1'b0, E_D, M_ALL, 1);
        add(6'b101011, J_FN, 1'b0, E_MA, M_ALL, 1);
        add(J_OP, J_FN, 1'b0, E_MW, M_NOAC, 1);
        // R-type sub with Zero high in EXEC
        add_rtype(6'b100010, 3'b110, 2);
        // addi
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 3);
        add(6'b001000, J_FN, 1'b1, E_D, M_ALL, 3);
        add(6'b001000, J_FN, 1'b1, E_MA, M_ALL, 3);
        add(J_OP, J_FN, 1'b1, E_IWB, M_NOAC, 3);
        // beq taken / not taken
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 4);
        add(6'b000100, J_FN, 1'b1, E_D, M_ALL, 4);
        add(6'b111111, J_FN, 1'b1, E_BR1, M_ALL, 4);
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 5);
        add(6'b000100, J_FN, 1'b0, E_D, M_ALL, 5);
        add(6'b000000, J_FN, 1'b0, E_BR0, M_ALL, 5);
        // j
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 6);
        add(6'b000010, J_FN, 1'b0, E_D, M_ALL, 6);
        add(6'b100011, J_FN, 1'b1, E_J, M_NOAC, 6);
        // unsupported opcode: two cycles, no retire
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 7);
        add(6'b111111, J_FN, 1'b0, E_DBAD, M_ALL, 7);
        // remaining funct codes
        add_rtype(6'b100100, 3'b000, 7);
        add_rtype(6'b100101, 3'b001, 8);
        add_rtype(6'b101010, 3'b111, 9);
        add_rtype(6'b000000, 3'b010, 10);
        add_rtype(6'b100000, 3'b010, 11);
        add(J_OP, J_FN, 1'b0, E_F, M_ALL, 12);

        // reset held across clock edges: everything low
        #2;
        check("reset outs", {16'h0, outs}, 32'h0);
        check("reset cnt", InstrCnt, 32'h0);
        repeat (2) @(negedge CLK);
        #1;
        check("reset outs clocked", {16'h0, outs}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            Opcode = vecs[i].op; Funct = vecs[i].fn; Zero = vecs[i].z;
            if (i == 0) RST_N = 1'b1;
            #1;
            check($sformatf("vec%0d outs", i), {16'h0, outs & vecs[i].mask},
                  {16'h0, vecs[i].exp & vecs[i].mask});
            check($sformatf("vec%0d cnt", i), InstrCnt, vecs[i].cnt);
        end

        // reset during MEMWB aborts without a clock edge
        step(6'b100011, J_FN, 1'b0);
        step(6'b100011, J_FN, 1'b0);
        step(J_OP, J_FN, 1'b0);
        step(J_OP, J_FN, 1'b0);
        check("abort pre RFWE", {31'h0, RFWE}, 32'h1);
        #1 RST_N = 1'b0;
        #1;
        check("abort RFWE", {31'h0, RFWE}, 32'h0);
        check("abort outs", {16'h0, outs}, 32'h0);
        check("abort cnt", InstrCnt, 32'h0);
        @(negedge CLK); #1;
        check("abort held outs", {16'h0, outs}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("release fetch outs", {16'h0, outs}, {16'h0, E_F});
        check("release cnt", InstrCnt, 32'h0);

        // counter wrap on a retired jump
        #1 force dut.instr_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.instr_cnt_q;
        check("preload cnt", InstrCnt, 32'hFFFF_FFFF);
        step(6'b000010, J_FN, 1'b0);
        check("wrap decode outs", {16'h0, outs}, {16'h0, E_D});
        step(J_OP, J_FN, 1'b0);
        check("wrap jump outs", {16'h0, outs & M_NOAC}, {16'h0, E_J & M_NOAC});
        check("wrap jump cnt", InstrCnt, 32'hFFFF_FFFF);
        step(J_OP, J_FN, 1'b0);
        check("wrap fetch outs", {16'h0, outs}, {16'h0, E_F});
        check("wrap cnt", InstrCnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
